// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO sequencer.
//   - Default widths and FIFO read latency used as parameter defaults.
//   - Sequencer state encoding.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_RD_LATENCY = 2;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 8;

  // Latency countdown width; covers RD_LATENCY-1 for the legal range 1..3.
  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPop   = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StFlush = 3'd4
  } seq_state_e;

endpackage

// File: rtl/uart_tx_fifo_sequencer_if.sv
// Handshake bundle between the FIFO read port, the sequencer and the transmitter.
//   fifo_empty : registered FIFO empty flag
//   fifo_data  : registered FIFO read data
//   fifo_rd_n  : active-low FIFO read strobe, one cycle per pop
//   tx_data    : byte presented to the transmitter
//   tx_valid   : tx_data valid
//   tx_ready   : transmitter accepts the byte
// master = sequencer side, slave = FIFO/transmitter side.
interface uart_tx_fifo_sequencer_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_n;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  tx_ready,
    output fifo_rd_n,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output tx_ready,
    input  fifo_rd_n,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/uart_tx_fifo_sequencer.sv
// Drains the UART transmit FIFO one byte at a time into the transmitter.
// Owns the FIFO read port, compensates for the FIFO's registered read data
// (RD_LATENCY edges) and its registered empty flag, supports flush and keeps a
// wrapping count of bytes accepted by the transmitter.
//
// Ports:
//   clock      : system clock
//   reset_n    : asynchronous active-low reset
//   enable     : 1 = sequencer may pop and transmit
//   flush      : 1 = discard FIFO contents and any pending byte
//   bus        : FIFO read port and transmitter handshake (master side)
//   busy       : 1 whenever the sequencer is not idle (registered)
//   sent_count : bytes accepted by the transmitter, wraps
module uart_tx_fifo_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         flush,
  uart_tx_fifo_sequencer_if.master     bus,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         sent_count
);

  // Countdown start: data is captured at the WAIT edge where the count is zero,
  // which is RD_LATENCY edges after the edge that sampled the read strobe.
  localparam logic [LAT_W-1:0] LatInit = LAT_W'(RD_LATENCY - 1);

  seq_state_e            state_q, state_d;
  logic                  rd_n_q, rd_n_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;

  logic                  accept;
  logic                  can_pop;
  logic [LAT_W-1:0]      lat_dec;

  assign accept  = tx_valid_q & bus.tx_ready;
  assign can_pop = enable & ~bus.fifo_empty;
  assign lat_dec = (lat_cnt_q == '0) ? '0 : lat_cnt_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    rd_n_d     = 1'b1;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    sent_d     = sent_q;
    lat_cnt_d  = lat_cnt_q;

    if (flush && (state_q != StFlush)) begin
      // Flush pre-empts everything, including valid stability in HOLD.
      // Carry over any read still in flight so FLUSH waits it out.
      state_d    = StFlush;
      tx_valid_d = 1'b0;
      if (state_q == StPop) begin
        lat_cnt_d = LatInit;
      end else if (state_q == StWait) begin
        lat_cnt_d = lat_dec;
      end else begin
        lat_cnt_d = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (can_pop) begin
            state_d = StPop;
            rd_n_d  = 1'b0;
          end
        end
        StPop: begin
          state_d   = StWait;
          lat_cnt_d = LatInit;
        end
        StWait: begin
          if (lat_cnt_q == '0) begin
            tx_data_d  = bus.fifo_data;
            tx_valid_d = 1'b1;
            state_d    = StHold;
          end else begin
            lat_cnt_d = lat_cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (accept) begin
            tx_valid_d = 1'b0;
            sent_d     = sent_q + 1'b1;
            // Empty is already current here, so a back-to-back pop is safe.
            if (can_pop) begin
              state_d = StPop;
              rd_n_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StFlush: begin
          tx_valid_d = 1'b0;
          lat_cnt_d  = lat_dec;
          if (!rd_n_q) begin
            // Pop sampled at this edge; its data lands RD_LATENCY edges later.
            lat_cnt_d = LatInit;
          end else if (!bus.fifo_empty) begin
            // Only pop after a non-pop cycle so empty reflects the last pop.
            rd_n_d = 1'b0;
          end else if (!flush && (lat_cnt_q == '0)) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rd_n_q     <= 1'b1;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_n_q     <= rd_n_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign bus.fifo_rd_n = rd_n_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign busy          = busy_q;
  assign sent_count    = sent_q;

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_sequencer;
  import uart_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned RL = 2;
  localparam int unsigned CW = 8;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic          flush   = 1'b0;
  logic          busy;
  logic [CW-1:0] sent_count;

  uart_tx_fifo_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_fifo_sequencer #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(RL),
    .CNT_WIDTH (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .sent_count(sent_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_pulses = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- FIFO model: registered empty, RL-deep registered read data
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem[$];
  logic [DW-1:0] pipe[RL];
  logic [DW-1:0] rd_val;

  assign bus.fifo_data = pipe[RL-1];

  initial begin
    bus.fifo_empty = 1'b1;
    for (int k = 0; k < int'(RL); k++) pipe[k] = '0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        mem.delete();
        for (int k = 0; k < int'(RL); k++) pipe[k] <= '0;
        bus.fifo_empty <= 1'b1;
      end else begin
        rd_val = pipe[0];
        if (!bus.fifo_rd_n && mem.size() > 0) rd_val = mem.pop_front();
        for (int k = int'(RL) - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= rd_val;
        if (wr_en) mem.push_back(wr_data);
        bus.fifo_empty <= (mem.size() == 0);
      end
    end
  end

  // ---------------- Monitor / scoreboard, samples on the falling edge
  logic          pv = 1'b0, pr = 1'b0, pf = 1'b0, prd_low = 1'b0;
  logic [DW-1:0] pd = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv      = 1'b0;
        prd_low = 1'b0;
      end else begin
        if (pv && !pr && !pf) begin
          check("hold_valid_stable", 32'(bus.tx_valid), 32'd1);
          check("hold_data_stable", 32'(bus.tx_data), 32'(pd));
        end
        if (!bus.fifo_rd_n) begin
          rd_pulses++;
          check("rd_n_while_empty", 32'(bus.fifo_empty), 32'd0);
          check("rd_n_single_cycle", 32'(prd_low), 32'd0);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, required no handshake", bus.tx_data);
          end else begin
            check("tx_data_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          end
        end
        pv      = bus.tx_valid;
        pr      = bus.tx_ready;
        pf      = flush;
        pd      = bus.tx_data;
        prd_low = ~bus.fifo_rd_n;
      end
    end
  end

  // ---------------- Stimulus helpers
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!bus.tx_valid && n < max) begin
      step(1);
      n++;
    end
    check(name, 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int n;

  initial begin
    bus.tx_ready = 1'b0;
    step(3);
    reset_n = 1'b1;

    // Reset values
    check("rst_rd_n", 32'(bus.fifo_rd_n), 32'd1);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", 32'(sent_count), 32'd0);

    // Single byte: cycle 0 = first cycle with empty low
    enable       = 1'b1;
    bus.tx_ready = 1'b1;
    base         = rd_pulses;
    exp_q.push_back(8'hA5);
    fifo_write(8'hA5);
    check("c0_rd_n", 32'(bus.fifo_rd_n), 32'd1);
    step(1);
    check("c1_rd_n", 32'(bus.fifo_rd_n), 32'd0);
    step(1);
    check("c2_rd_n", 32'(bus.fifo_rd_n), 32'd1);
    check("c2_busy", 32'(busy), 32'd1);
    step(1);
    check("c3_tx_valid", 32'(bus.tx_valid), 32'd0);
    step(1);
    check("c4_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("c4_tx_data", 32'(bus.tx_data), 32'hA5);
    step(1);
    check("c5_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("c5_sent", 32'(sent_count), 32'd1);
    check("c5_busy", 32'(busy), 32'd0);
    check("single_pulses", 32'(rd_pulses - base), 32'd1);

    // Reset mid-HOLD
    bus.tx_ready = 1'b0;
    fifo_write(8'h5A);
    wait_valid("rst_hold_reach", 20);
    reset_n = 1'b0;
    #2;
    check("rsthold_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rsthold_rd_n", 32'(bus.fifo_rd_n), 32'd1);
    check("rsthold_sent", 32'(sent_count), 32'd0);
    check("rsthold_busy", 32'(busy), 32'd0);
    check("rsthold_tx_data", 32'(bus.tx_data), 32'd0);
    step(2);
    reset_n = 1'b1;

    // Backpressure
    base = rd_pulses;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    fifo_write(8'h01);
    fifo_write(8'h02);
    fifo_write(8'h03);
    wait_valid("bp_reach_hold", 20);
    step(10);
    check("bp_tx_data", 32'(bus.tx_data), 32'h01);
    check("bp_no_extra_pop", 32'(rd_pulses - base), 32'd1);
    bus.tx_ready = 1'b1;
    wait_drain("bp_drain", 60);
    step(5);
    check("bp_sent", 32'(sent_count), 32'd3);
    check("bp_pulses", 32'(rd_pulses - base), 32'd3);
    check("bp_busy", 32'(busy), 32'd0);

    // Empty boundary: single byte, no second pop
    base = rd_pulses;
    exp_q.push_back(8'h7E);
    fifo_write(8'h7E);
    wait_drain("empty_drain", 20);
    step(10);
    check("empty_pulses", 32'(rd_pulses - base), 32'd1);
    check("empty_sent", 32'(sent_count), 32'd4);
    check("empty_busy", 32'(busy), 32'd0);

    // Flush during HOLD with 4 bytes still queued
    bus.tx_ready = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 5; i++) fifo_write(8'(8'h10 + i));
    wait_valid("flush_reach_hold", 20);
    flush = 1'b1;
    step(1);
    check("flush_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("flush_sent", 32'(sent_count), 32'd4);
    step(20);
    check("flush_busy_held", 32'(busy), 32'd1);
    check("flush_fifo_emptied", 32'(mem.size()), 32'd0);
    flush = 1'b0;
    step(5);
    check("flush_exit_busy", 32'(busy), 32'd0);
    check("flush_pulses", 32'(rd_pulses - base), 32'd5);
    check("flush_sent_after", 32'(sent_count), 32'd4);

    // Enable dropped while a pop is in flight
    enable = 1'b0;
    fifo_write(8'h33);
    fifo_write(8'h44);
    base   = rd_pulses;
    enable = 1'b1;
    n = 0;
    while (bus.fifo_rd_n && n < 10) begin
      step(1);
      n++;
    end
    check("en_pop_seen", 32'(bus.fifo_rd_n), 32'd0);
    step(1);
    enable = 1'b0;
    wait_valid("en_reach_hold", 10);
    check("en_tx_data", 32'(bus.tx_data), 32'h33);
    exp_q.push_back(8'h33);
    bus.tx_ready = 1'b1;
    wait_drain("en_drain", 10);
    step(10);
    check("en_pulses", 32'(rd_pulses - base), 32'd1);
    check("en_busy", 32'(busy), 32'd0);
    check("en_fifo_left", 32'(mem.size()), 32'd1);
    do_reset();

    // sent_count wrap over 256 bytes
    enable       = 1'b1;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'(i));
      fifo_write(8'(i));
      wait_drain("wrap_drain", 20);
      if (i == 254) begin
        step(1);
        check("wrap_sent_255", 32'(sent_count), 32'd255);
      end
    end
    step(2);
    check("wrap_sent_0", 32'(sent_count), 32'd0);
    check("wrap_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
